data_mem_system_param: RTL
==========================

Name: data_mem_system_param

Overview:
- Parametrised successor to the fixed-size data memory system behind the single-cycle RISC-V core.
- Direct-mapped, write-through, no-write-allocate data cache in front of an internal main-memory array.
- Geometry and main-memory latency are configurable.
- Asserts stall to freeze the core's PC during misses and writes; the core holds MemRead, MemWrite, WordAddress and DataIn stable while stall=1.

Parameters:
- ADDR_W, 10, word-address width; main memory holds 2^ADDR_W words.
- DATA_W, 32, word width.
- NUM_LINES, 4, cache lines; power of two, ≥2.
- WORDS_PER_BLOCK, 4, words per line; power of two, ≥1.
- MEM_LATENCY, 4, main-memory access cycles; ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- MemRead  input  1  load request.
- MemWrite  input  1  store request.
- WordAddress  input  ADDR_W  word address.
- DataIn  input  DATA_W  store data.
- stall  output  1  freeze core; combinational from state, counter and request.
- DataOut  output  DATA_W  load data; combinational.

Behaviour:
- Address split: offset = low log2(WORDS_PER_BLOCK) bits; index = next log2(NUM_LINES) bits; tag = remaining bits.
- hit = valid[index] && tag_arr[index] == tag.
- Reset (rst=0, async): state=IDLE, counter=0, all valid bits cleared.
  - Main-memory and data/tag arrays are not cleared.
  - Outputs during and after reset: stall=0, DataOut=0.
- Reset mid-miss or mid-write aborts the operation; no partial line fill; no main-memory write.
- State IDLE:
  - MemWrite=1 (wins over MemRead when both are high):
    - MEM_LATENCY=1: stall=0; commit at this edge.
    - Otherwise: stall=1; go to WRITE with cnt=1.
  - MemRead=1 and hit: stall=0, DataOut = cached word, zero latency.
  - MemRead=1 and miss: stall=1; go to MISS_WAIT with cnt=0.
  - No request: stall=0, DataOut=0.
- State MISS_WAIT:
  - stall=1 and DataOut=0 throughout.
  - cnt increments each cycle.
  - At the edge where cnt==MEM_LATENCY-1: whole block (base = address with offset zeroed) is copied from main memory into the line; tag written; valid set; return to IDLE.
  - The next IDLE cycle hits.
  - Total read-miss stall = MEM_LATENCY+1 cycles.
- State WRITE:
  - stall = (cnt != MEM_LATENCY-1); cnt increments while stall=1.
  - When cnt==MEM_LATENCY-1: stall=0. At that edge: main memory[addr] ← DataIn; cached word updated if hit (valid/tag unchanged); return to IDLE.
  - Write miss does not allocate.
  - Total write stall = MEM_LATENCY-1 cycles.
- Commit rule: a store commits exactly once, at the only edge where stall=0 with the request present.
- Back-to-back accesses: the next request is evaluated in IDLE on the cycle after commit.
- Counter width: clog2(MEM_LATENCY)+1; never wraps.
- Read of a line currently valid under a different tag: the miss replaces it.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined: adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0 and saturating at all-ones.
  - miss_count increments on each IDLE→MISS_WAIT transition.
  - hit_count increments on each IDLE read hit not immediately following a fill (tracked with a one-cycle fill flag).
  - Write hits are not counted.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan (defaults ADDR_W=10, NUM_LINES=4, WORDS_PER_BLOCK=4, MEM_LATENCY=4):
- Cold read miss: reset; mem[0x010]=0xDEADBEEF; MemRead addr 0x010 → stall=1 for exactly 5 cycles, then stall=0 with DataOut=0xDEADBEEF; mem[0x011..0x013] now hit with 0 stall.
- Write hit: after the scenario above, MemWrite addr 0x012, DataIn=0x12345678 → stall=1 for 3 cycles, commit on the 4th cycle; read 0x012 → 0x12345678 with no stall; mem[0x012]=0x12345678.
- Write miss, no allocate: MemWrite addr 0x200, 0xA5A5A5A5 → 3 stall cycles; mem[0x200] updated; subsequent read of 0x200 misses (5 stall cycles) and returns 0xA5A5A5A5.
- Conflict eviction: read 0x010, then 0x050 (same index 0, different tag), then 0x010 → three misses, each 5 stall cycles, each returning the correct data.
- Reset mid-miss: assert rst=0 on the 2nd MISS_WAIT cycle → stall=0 and DataOut=0 immediately; after release, the same read misses again for the full 5 cycles.
- With CACHE_STATS_EN, after the first scenario's read plus 3 further hits: miss_count=1, hit_count=3.

Source files
------------

// File: rtl/data_mem_system_param.sv
// Parametrised data memory system: direct-mapped, write-through,
// no-write-allocate cache in front of an internal main-memory array.
// Optional build macro: CACHE_STATS_EN (adds hit/miss counters).
// Ports:
//   clk         - system clock, rising edge
//   rst         - asynchronous active-low reset
//   MemRead     - load request
//   MemWrite    - store request (wins over MemRead)
//   WordAddress - word address
//   DataIn      - store data
//   stall       - freeze the core while a miss or store is in flight
//   DataOut     - load data (zero unless a read hits in IDLE)
//   hit_count   - saturating read-hit counter (CACHE_STATS_EN only)
//   miss_count  - saturating read-miss counter (CACHE_STATS_EN only)
module data_mem_system_param #(
    parameter int ADDR_W          = 10,
    parameter int DATA_W          = 32,
    parameter int NUM_LINES       = 4,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int MEM_LATENCY     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] WordAddress,
    input  logic [DATA_W-1:0] DataIn,
    output logic              stall,
    output logic [DATA_W-1:0] DataOut
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int OFF_W     = $clog2(WORDS_PER_BLOCK);
    localparam int IDX_W     = $clog2(NUM_LINES);
    localparam int CW        = OFF_W + IDX_W;
    localparam int TAG_W     = ADDR_W - CW;
    localparam int CNT_W     = $clog2(MEM_LATENCY) + 1;
    localparam int MEM_WORDS = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        MISS_WAIT,
        WRITE
    } state_t;

    state_t state;
    logic [CNT_W-1:0] cnt;

    logic [DATA_W-1:0] mainMem [MEM_WORDS];
    logic [DATA_W-1:0] dataArr [NUM_LINES*WORDS_PER_BLOCK];
    logic [TAG_W-1:0]  tagArr  [NUM_LINES];
    logic [NUM_LINES-1:0] valid;

    logic [IDX_W-1:0]  index;
    logic [TAG_W-1:0]  tag;
    logic [CW-1:0]     cIdx;
    logic [ADDR_W-1:0] baseAddr;
    logic hit;
    logic lastCycle;
    logic memWe;
    logic cacheWe;
    logic fillEn;
    logic readHit;

    // {index, offset} are the low address bits, so they address the
    // flattened line/word data array directly.
    assign index     = WordAddress[CW-1:OFF_W];
    assign tag       = WordAddress[ADDR_W-1:CW];
    assign cIdx      = WordAddress[CW-1:0];
    assign baseAddr  = WordAddress & ~ADDR_W'(WORDS_PER_BLOCK - 1);
    assign hit       = valid[index] && (tagArr[index] == tag);
    assign lastCycle = (cnt == LAST);
    assign cacheWe   = memWe && hit;
    assign readHit   = rst && (state == IDLE) && MemRead && !MemWrite && hit;
    assign DataOut   = readHit ? dataArr[cIdx] : '0;

    // Gating on rst keeps outputs quiet and blocks any array write
    // while reset is held.
    always_comb begin
        stall  = 1'b0;
        memWe  = 1'b0;
        fillEn = 1'b0;
        if (rst) begin
            unique case (state)
                IDLE: begin
                    if (MemWrite) begin
                        stall = (MEM_LATENCY != 1);
                        memWe = (MEM_LATENCY == 1);
                    end else if (MemRead) begin
                        stall = !hit;
                    end
                end
                MISS_WAIT: begin
                    stall  = 1'b1;
                    fillEn = lastCycle;
                end
                WRITE: begin
                    stall = !lastCycle;
                    memWe = lastCycle;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            valid <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (MemWrite) begin
                        if (MEM_LATENCY != 1) begin
                            state <= WRITE;
                            cnt   <= CNT_W'(1);
                        end
                    end else if (MemRead && !hit) begin
                        state <= MISS_WAIT;
                        cnt   <= '0;
                    end
                end
                MISS_WAIT: begin
                    if (lastCycle) begin
                        valid[index] <= 1'b1;
                        state        <= IDLE;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    if (lastCycle) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Storage arrays are never cleared by reset.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mainMem[WordAddress] <= DataIn;
        end
        if (cacheWe) begin
            dataArr[cIdx] <= DataIn;
        end
        if (fillEn) begin
            for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
                dataArr[CW'(int'(index) * WORDS_PER_BLOCK + w)] <=
                    mainMem[baseAddr + ADDR_W'(w)];
            end
            tagArr[index] <= tag;
        end
    end

`ifdef CACHE_STATS_EN
    // The IDLE cycle right after a fill replays the missed read as a
    // hit; fillFlag keeps it from being counted twice.
    logic fillFlag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            fillFlag   <= 1'b0;
        end else begin
            fillFlag <= fillEn;
            if (state == IDLE && MemRead && !MemWrite) begin
                if (!hit) begin
                    if (miss_count != '1) begin
                        miss_count <= miss_count + 32'd1;
                    end
                end else if (!fillFlag) begin
                    if (hit_count != '1) begin
                        hit_count <= hit_count + 32'd1;
                    end
                end
            end
        end
    end
`endif

endmodule
